// File: rtl/cci_mpf_prim_lockstep_qos_buffer_if.sv
// Request/response bundle for the N-channel lockstep QoS buffer.
// The producer side holds the master modport and the buffer holds the slave modport.
interface cci_mpf_prim_lockstep_qos_buffer_if #(
  parameter int N_CHANNELS  = 2,
  parameter int N_DATA_BITS = 64,
  parameter int N_ENTRIES   = 16
);
  localparam int BW = $clog2(N_ENTRIES * 4) + 1;

  logic [N_CHANNELS-1:0]             enq_valid;
  logic [2*N_CHANNELS-1:0]           enq_len;
  logic [N_CHANNELS*N_DATA_BITS-1:0] enq_data;
  logic [N_CHANNELS-1:0]             almost_full;
  logic [N_CHANNELS-1:0]             first_valid;
  logic [2*N_CHANNELS-1:0]           first_len;
  logic [N_CHANNELS*N_DATA_BITS-1:0] first_data;
  logic                              not_empty;
  logic                              deq_en;
  logic                              overflow;
  logic                              setqos;
  logic                              setqos_enable;
  logic [7:0]                        setqos_beat_delta_threshold;
  logic [7:0]                        setqos_min_beat_threshold;
  logic [N_CHANNELS*BW-1:0]          channel_beats;

  modport master (
    output enq_valid, enq_len, enq_data, deq_en,
    output setqos, setqos_enable, setqos_beat_delta_threshold, setqos_min_beat_threshold,
    input  almost_full, first_valid, first_len, first_data, not_empty, overflow, channel_beats
  );

  modport slave (
    input  enq_valid, enq_len, enq_data, deq_en,
    input  setqos, setqos_enable, setqos_beat_delta_threshold, setqos_min_beat_threshold,
    output almost_full, first_valid, first_len, first_data, not_empty, overflow, channel_beats
  );
endinterface

// File: rtl/cci_mpf_prim_lockstep_qos_buffer.sv
// N-channel lockstep request FIFO: every entry carries one slot per channel, so all lanes move
// together. Per-channel beat counts feed a one-at-a-time QoS throttle that raises almost_full.
module cci_mpf_prim_lockstep_qos_buffer #(
  parameter int N_CHANNELS      = 2,
  parameter int N_DATA_BITS     = 64,
  parameter int N_ENTRIES       = 16,
  parameter int THRESHOLD       = 4,
  parameter int THROTTLE_CYCLES = 8
) (
  input logic clk,
  input logic reset,
  cci_mpf_prim_lockstep_qos_buffer_if.slave buf_if
);
  localparam int BW   = $clog2(N_ENTRIES * 4) + 1;
  localparam int AW   = $clog2(N_ENTRIES);
  localparam int CNTW = AW + 1;
  localparam int TW   = (BW > 8) ? BW : 8;
  localparam int CW   = TW + 1;

  typedef enum logic [1:0] {IDLE, THROTTLE, HOLDOFF} qos_state_e;

  logic [N_CHANNELS-1:0]             mem_valid [N_ENTRIES];
  logic [2*N_CHANNELS-1:0]           mem_len   [N_ENTRIES];
  logic [N_CHANNELS*N_DATA_BITS-1:0] mem_data  [N_ENTRIES];

  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]         count_q, count_d;
  logic                    fifo_af_q, overflow_q;
  logic                    enq_any, do_enq, do_deq, not_empty;
  logic [N_CHANNELS-1:0]   head_valid;
  logic [2*N_CHANNELS-1:0] head_len;

  logic [BW-1:0]           beats_q [N_CHANNELS];
  logic [BW-1:0]           beats_d [N_CHANNELS];
  logic                    qos_enable_q;
  logic [TW-1:0]           delta_q, min_q;
  qos_state_e              state_q [N_CHANNELS];
  qos_state_e              state_d [N_CHANNELS];
  logic [5:0]              cyc_q   [N_CHANNELS];
  logic [5:0]              cyc_d   [N_CHANNELS];
  logic [CW-1:0]           other_min [N_CHANNELS];
  logic [N_CHANNELS-1:0]   trig, blocked, af_vec;
  logic [N_CHANNELS*BW-1:0] beats_flat;

  assign enq_any    = |buf_if.enq_valid;
  assign do_enq     = enq_any && (count_q < CNTW'(N_ENTRIES));
  assign do_deq     = buf_if.deq_en && (count_q != '0);
  assign count_d    = count_q + CNTW'(do_enq) - CNTW'(do_deq);
  assign not_empty  = (count_q != '0);
  assign head_valid = mem_valid[rd_ptr_q];
  assign head_len   = mem_len[rd_ptr_q];

  assign buf_if.not_empty   = not_empty;
  assign buf_if.first_valid = head_valid & {N_CHANNELS{not_empty}};
  assign buf_if.first_len   = head_len;
  assign buf_if.first_data  = mem_data[rd_ptr_q];
  assign buf_if.overflow    = overflow_q;

  // Payload storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_valid[wr_ptr_q] <= buf_if.enq_valid;
      mem_len[wr_ptr_q]   <= buf_if.enq_len;
      mem_data[wr_ptr_q]  <= buf_if.enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_af_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + AW'(do_enq);
      rd_ptr_q   <= rd_ptr_q + AW'(do_deq);
      count_q    <= count_d;
      fifo_af_q  <= ((CNTW'(N_ENTRIES) - count_d) <= CNTW'(THRESHOLD));
      overflow_q <= overflow_q | (enq_any && !do_enq);
    end
  end

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      beats_d[c] = beats_q[c]
        + ((do_enq && buf_if.enq_valid[c]) ? (BW'(buf_if.enq_len[2*c +: 2]) + BW'(1)) : '0)
        - ((do_deq && head_valid[c]) ? (BW'(head_len[2*c +: 2]) + BW'(1)) : '0);
    end
  end

  // Trigger: a lane is far ahead of the slowest other lane, and that lane is itself non-trivial.
  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      other_min[c] = '1;
      for (int j = 0; j < N_CHANNELS; j++) begin
        if ((j != c) && (CW'(beats_q[j]) < other_min[c])) other_min[c] = CW'(beats_q[j]);
      end
      trig[c] = (N_CHANNELS > 1) && qos_enable_q
             && (CW'(beats_q[c]) > (other_min[c] + CW'(delta_q)))
             && (other_min[c] > CW'(min_q));
    end
  end

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      blocked[c] = 1'b0;
      for (int j = 0; j < N_CHANNELS; j++) begin
        if ((j != c) && (state_q[j] != IDLE)) blocked[c] = 1'b1;
        if ((j < c) && trig[j])               blocked[c] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cyc_d[c]   = cyc_q[c];
      case (state_q[c])
        IDLE: begin
          if (trig[c] && !blocked[c]) begin
            state_d[c] = THROTTLE;
            cyc_d[c]   = 6'(THROTTLE_CYCLES);
          end
        end
        THROTTLE: begin
          if (cyc_q[c] == 6'd1) begin
            state_d[c] = HOLDOFF;
            cyc_d[c]   = 6'(THROTTLE_CYCLES);
          end else begin
            cyc_d[c] = cyc_q[c] - 6'd1;
          end
        end
        HOLDOFF: begin
          if (cyc_q[c] == 6'd1) state_d[c] = IDLE;
          else                  cyc_d[c]   = cyc_q[c] - 6'd1;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qos_enable_q <= 1'b1;
      delta_q      <= TW'(6);
      min_q        <= '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
        beats_q[c] <= '0;
        state_q[c] <= IDLE;
        cyc_q[c]   <= '0;
      end
    end else begin
      if (buf_if.setqos) begin
        qos_enable_q <= buf_if.setqos_enable;
        delta_q      <= TW'(buf_if.setqos_beat_delta_threshold);
        min_q        <= TW'(buf_if.setqos_min_beat_threshold);
      end
      for (int c = 0; c < N_CHANNELS; c++) begin
        beats_q[c] <= beats_d[c];
        state_q[c] <= state_d[c];
        cyc_q[c]   <= cyc_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      af_vec[c]             = fifo_af_q || ((N_CHANNELS > 1) && (state_q[c] == THROTTLE));
      beats_flat[c*BW +: BW] = beats_q[c];
    end
  end

  assign buf_if.almost_full   = af_vec;
  assign buf_if.channel_beats = beats_flat;
endmodule

// File: tb/tb_cci_mpf_prim_lockstep_qos_buffer.sv
// Directed bench for the lockstep QoS buffer: a 2-lane instance for FIFO/beat/QoS behaviour
// and a 3-lane instance for the lowest-index tie-break and the enable switch.
module tb_cci_mpf_prim_lockstep_qos_buffer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cci_mpf_prim_lockstep_qos_buffer_if #(.N_CHANNELS(2), .N_DATA_BITS(64), .N_ENTRIES(16)) b2 ();
  cci_mpf_prim_lockstep_qos_buffer_if #(.N_CHANNELS(3), .N_DATA_BITS(16), .N_ENTRIES(16)) b3 ();

  cci_mpf_prim_lockstep_qos_buffer #(
    .N_CHANNELS(2), .N_DATA_BITS(64), .N_ENTRIES(16), .THRESHOLD(4), .THROTTLE_CYCLES(8)
  ) dut2 (.clk(clk), .reset(reset), .buf_if(b2));

  cci_mpf_prim_lockstep_qos_buffer #(
    .N_CHANNELS(3), .N_DATA_BITS(16), .N_ENTRIES(16), .THRESHOLD(4), .THROTTLE_CYCLES(8)
  ) dut3 (.clk(clk), .reset(reset), .buf_if(b3));

  typedef struct {
    logic [1:0]  ev;
    logic [3:0]  len;
    logic [15:0] d;
    logic        deq;
    logic        ne;
    logic [1:0]  fv;
    logic [3:0]  flen;
    logic [15:0] fd;
    logic [6:0]  b0;
    logic [6:0]  b1;
    logic [1:0]  af;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk2(input logic [15:0] d);
    return {48'h0, ~d, 48'h0, d};
  endfunction

  function automatic logic [6:0] beat2(input int c);
    return b2.channel_beats[c*7 +: 7];
  endfunction

  function automatic logic [6:0] beat3(input int c);
    return b3.channel_beats[c*7 +: 7];
  endfunction

  task automatic idle_inputs();
    b2.enq_valid = '0; b2.enq_len = '0; b2.enq_data = '0; b2.deq_en = 1'b0;
    b2.setqos = 1'b0; b2.setqos_enable = 1'b0;
    b2.setqos_beat_delta_threshold = '0; b2.setqos_min_beat_threshold = '0;
    b3.enq_valid = '0; b3.enq_len = '0; b3.enq_data = '0; b3.deq_en = 1'b0;
    b3.setqos = 1'b0; b3.setqos_enable = 1'b0;
    b3.setqos_beat_delta_threshold = '0; b3.setqos_min_beat_threshold = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step2(input logic [1:0] ev, input logic [3:0] len, input logic [15:0] d,
                       input logic deq);
    b2.enq_valid = ev; b2.enq_len = len; b2.enq_data = mk2(d); b2.deq_en = deq;
    @(posedge clk);
    #1;
    b2.enq_valid = '0; b2.enq_len = '0; b2.enq_data = '0; b2.deq_en = 1'b0;
  endtask

  task automatic step3(input logic [2:0] ev, input logic [5:0] len, input logic deq);
    b3.enq_valid = ev; b3.enq_len = len; b3.deq_en = deq;
    @(posedge clk);
    #1;
    b3.enq_valid = '0; b3.enq_len = '0; b3.deq_en = 1'b0;
  endtask

  task automatic setq2(input logic en, input logic [7:0] delta, input logic [7:0] mn);
    b2.setqos = 1'b1; b2.setqos_enable = en;
    b2.setqos_beat_delta_threshold = delta; b2.setqos_min_beat_threshold = mn;
    @(posedge clk);
    #1;
    b2.setqos = 1'b0;
  endtask

  task automatic setq3(input logic en, input logic [7:0] delta, input logic [7:0] mn);
    b3.setqos = 1'b1; b3.setqos_enable = en;
    b3.setqos_beat_delta_threshold = delta; b3.setqos_min_beat_threshold = mn;
    @(posedge clk);
    #1;
    b3.setqos = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ev     len      d       deq   ne    fv     flen     fd      b0    b1    af
    vecs[0] = '{2'b01, 4'b0011, 16'hA1, 1'b0, 1'b1, 2'b01, 4'b0011, 16'hA1, 7'd4, 7'd0, 2'b00};
    vecs[1] = '{2'b10, 4'b0000, 16'hB2, 1'b0, 1'b1, 2'b01, 4'b0011, 16'hA1, 7'd4, 7'd1, 2'b00};
    vecs[2] = '{2'b00, 4'b0000, 16'h00, 1'b1, 1'b1, 2'b10, 4'b0000, 16'hB2, 7'd0, 7'd1, 2'b00};
    vecs[3] = '{2'b00, 4'b0000, 16'h00, 1'b1, 1'b0, 2'b00, 4'b0000, 16'h00, 7'd0, 7'd0, 2'b00};
    vecs[4] = '{2'b00, 4'b0000, 16'h00, 1'b1, 1'b0, 2'b00, 4'b0000, 16'h00, 7'd0, 7'd0, 2'b00};
    vecs[5] = '{2'b11, 4'b1001, 16'hC3, 1'b0, 1'b1, 2'b11, 4'b1001, 16'hC3, 7'd2, 7'd3, 2'b00};
    vecs[6] = '{2'b11, 4'b0000, 16'hD4, 1'b1, 1'b1, 2'b11, 4'b0000, 16'hD4, 7'd1, 7'd1, 2'b00};
    vecs[7] = '{2'b00, 4'b0000, 16'h00, 1'b1, 1'b0, 2'b00, 4'b0000, 16'h00, 7'd0, 7'd0, 2'b00};

    do_reset();
    chk("rst_not_empty", b2.not_empty, 1'b0);
    chk("rst_first_valid", b2.first_valid, 2'b00);
    chk("rst_almost_full", b2.almost_full, 2'b00);
    chk("rst_overflow", b2.overflow, 1'b0);
    chk("rst_beats", b2.channel_beats, 14'd0);

    // Lockstep ordering, empty-deq, and simultaneous enq+deq vectors.
    for (int i = 0; i < 8; i++) begin
      step2(vecs[i].ev, vecs[i].len, vecs[i].d, vecs[i].deq);
      chk($sformatf("vec%0d_not_empty", i), b2.not_empty, vecs[i].ne);
      chk($sformatf("vec%0d_first_valid", i), b2.first_valid, vecs[i].fv);
      chk($sformatf("vec%0d_beats0", i), beat2(0), vecs[i].b0);
      chk($sformatf("vec%0d_beats1", i), beat2(1), vecs[i].b1);
      chk($sformatf("vec%0d_almost_full", i), b2.almost_full, vecs[i].af);
      if (vecs[i].ne) begin
        chk($sformatf("vec%0d_first_len", i), b2.first_len, vecs[i].flen);
        chk($sformatf("vec%0d_first_data", i), b2.first_data, mk2(vecs[i].fd));
      end
    end

    // Fill to full, overflow, enq+deq at full, then drain.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step2(2'b11, 4'b0000, 16'(i), 1'b0);
      if (i == 10) chk("fill_af_after_11", b2.almost_full, 2'b00);
      if (i == 11) chk("fill_af_after_12", b2.almost_full, 2'b11);
    end
    chk("full_overflow_clear", b2.overflow, 1'b0);
    chk("full_beats0", beat2(0), 7'd16);
    chk("full_beats1", beat2(1), 7'd16);
    step2(2'b11, 4'b0000, 16'hEE, 1'b0);
    chk("ovf_set", b2.overflow, 1'b1);
    chk("ovf_beats_unchanged", beat2(0), 7'd16);
    chk("ovf_head_data", b2.first_data, mk2(16'd0));
    step2(2'b11, 4'b0000, 16'hFF, 1'b1);
    chk("full_enqdeq_overflow", b2.overflow, 1'b1);
    chk("full_enqdeq_beats1", beat2(1), 7'd15);
    chk("full_enqdeq_af", b2.almost_full, 2'b11);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d_not_empty", i), b2.not_empty, 1'b1);
      chk($sformatf("drain%0d_data", i), b2.first_data, mk2(16'(i)));
      step2(2'b00, 4'b0000, 16'h0, 1'b1);
    end
    chk("drained_not_empty", b2.not_empty, 1'b0);
    chk("drained_first_valid", b2.first_valid, 2'b00);
    chk("drained_beats", b2.channel_beats, 14'd0);
    chk("drained_af", b2.almost_full, 2'b00);
    chk("drained_overflow_sticky", b2.overflow, 1'b1);

    // QoS trigger on lane 0, then lane 1 held off until lane 0's hold-off ends.
    do_reset();
    step2(2'b11, 4'b0011, 16'h0, 1'b0);
    step2(2'b11, 4'b0011, 16'h0, 1'b0);
    chk("qos_no_trig_at_8_2", b2.almost_full, 2'b00);
    step2(2'b01, 4'b0001, 16'h0, 1'b0);
    chk("qos_beats0_10", beat2(0), 7'd10);
    chk("qos_beats1_2", beat2(1), 7'd2);
    chk("qos_af_before_throttle", b2.almost_full, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step2(2'b00, 4'b0000, 16'h0, 1'b0);
      chk($sformatf("qos_throttle_cyc%0d", i), b2.almost_full, 2'b01);
    end
    step2(2'b00, 4'b0000, 16'h0, 1'b1);
    chk("qos_throttle_end", b2.almost_full, 2'b00);
    step2(2'b00, 4'b0000, 16'h0, 1'b1);
    step2(2'b00, 4'b0000, 16'h0, 1'b1);
    chk("qos_drained", b2.not_empty, 1'b0);
    step2(2'b11, 4'b1100, 16'h0, 1'b0);
    step2(2'b10, 4'b1100, 16'h0, 1'b0);
    chk("qos_c1_beats", beat2(1), 7'd8);
    chk("qos_c0_beats", beat2(0), 7'd1);
    chk("qos_holdoff_blk0", b2.almost_full, 2'b00);
    for (int i = 1; i < 5; i++) begin
      step2(2'b00, 4'b0000, 16'h0, 1'b0);
      chk($sformatf("qos_holdoff_blk%0d", i), b2.almost_full, 2'b00);
    end
    step2(2'b00, 4'b0000, 16'h0, 1'b0);
    chk("qos_c1_throttles_after_holdoff", b2.almost_full, 2'b10);

    // Three lanes: lanes 0 and 2 qualify together, lane 0 wins.
    do_reset();
    step3(3'b111, 6'b11_01_11, 1'b0);
    step3(3'b101, 6'b11_00_11, 1'b0);
    step3(3'b101, 6'b01_00_01, 1'b0);
    chk("tie_beats2", beat3(2), 7'd10);
    chk("tie_af_before", b3.almost_full, 3'b000);
    for (int i = 0; i < 8; i++) begin
      step3(3'b000, 6'b0, 1'b0);
      chk($sformatf("tie_throttle_cyc%0d", i), b3.almost_full, 3'b001);
    end
    step3(3'b000, 6'b0, 1'b0);
    chk("tie_holdoff", b3.almost_full, 3'b000);

    // QoS disabled: a 40-beat disparity does not throttle until re-enabled.
    do_reset();
    setq3(1'b0, 8'd6, 8'd0);
    step3(3'b111, 6'b00_00_00, 1'b0);
    for (int i = 0; i < 10; i++) step3(3'b001, 6'b00_00_11, 1'b0);
    chk("dis_beats0", beat3(0), 7'd41);
    chk("dis_beats1", beat3(1), 7'd1);
    for (int i = 0; i < 3; i++) begin
      step3(3'b000, 6'b0, 1'b0);
      chk($sformatf("dis_no_trig%0d", i), b3.almost_full, 3'b000);
    end
    setq3(1'b1, 8'd6, 8'd0);
    chk("reen_af_same_cycle", b3.almost_full, 3'b000);
    step3(3'b000, 6'b0, 1'b0);
    chk("reen_af_throttle", b3.almost_full, 3'b001);

    // Reset in the middle of a throttle with 7 entries queued.
    do_reset();
    setq2(1'b1, 8'd2, 8'd0);
    step2(2'b11, 4'b0011, 16'h0, 1'b0);
    step2(2'b01, 4'b0011, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step2(2'b01, 4'b0000, 16'h0, 1'b0);
    chk("mid_af_throttle", b2.almost_full, 2'b01);
    chk("mid_beats0", beat2(0), 7'd13);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_not_empty", b2.not_empty, 1'b0);
    chk("mid_rst_first_valid", b2.first_valid, 2'b00);
    chk("mid_rst_af", b2.almost_full, 2'b00);
    chk("mid_rst_overflow", b2.overflow, 1'b0);
    chk("mid_rst_beats", b2.channel_beats, 14'd0);
    reset = 1'b0;
    step2(2'b11, 4'b0011, 16'h0, 1'b0);
    step2(2'b00, 4'b0000, 16'h0, 1'b0);
    chk("cfg_default_delta_a", b2.almost_full, 2'b00);
    step2(2'b00, 4'b0000, 16'h0, 1'b0);
    chk("cfg_default_delta_b", b2.almost_full, 2'b00);
    step2(2'b01, 4'b0011, 16'h0, 1'b0);
    step2(2'b00, 4'b0000, 16'h0, 1'b0);
    chk("cfg_default_trig", b2.almost_full, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
